// File: rtl/asym_ram_write_packer.sv
// Byte-stream to wide-word packer feeding port A of the asymmetric RAM.
// Packs RATIO bytes per word and writes them at sequential addresses from 0.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start                   restart a fill from address 0 (beats a same-cycle byte)
//   s_valid/s_data/s_last   byte stream in; s_last flushes a padded partial word
//   s_ready                 high only while filling
//   a_rw/a_w_addr/a_indata  one-cycle port-A write strobe, address and word
//   word_count/full/done    words written since start, DEPTH reached, s_last word written
module asym_ram_write_packer #(
    parameter int                   DATA_IN_W  = 8,
    parameter int                   WIDTH_A    = 16,
    parameter int                   DEPTH      = 256,
    parameter int                   ADDR_W     = 8,
    parameter int                   BIG_ENDIAN = 0,
    parameter logic [DATA_IN_W-1:0] PAD_BYTE   = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 s_valid,
    input  logic [DATA_IN_W-1:0] s_data,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic                 a_rw,
    output logic [ADDR_W-1:0]    a_w_addr,
    output logic [WIDTH_A-1:0]   a_indata,
    output logic [ADDR_W:0]      word_count,
    output logic                 full,
    output logic                 done
);

    localparam int RATIO  = WIDTH_A / DATA_IN_W;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [WIDTH_A-1:0] PAD_WORD  = {RATIO{PAD_BYTE}};
    localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FULL
    } state_t;

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, full_d;
    logic                done_q, done_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WIDTH_A-1:0]  data_q, data_d;
    logic [WIDTH_A-1:0]  buf_q, buf_d;

    logic                accept;
    logic                word_end;
    logic [LANE_W-1:0]   phys_lane;
    logic [WIDTH_A-1:0]  packed_w;
    int                  ofs;

    assign s_ready = (state_q == S_FILL);
    assign accept  = s_valid && s_ready;

    // Buffer lanes not yet written hold PAD_BYTE, so a flushed partial
    // word needs no separate padding step.
    always_comb begin
        phys_lane = (BIG_ENDIAN != 0) ? (LAST_LANE - lane_q) : lane_q;
        ofs       = int'(phys_lane) * DATA_IN_W;
        packed_w  = buf_q;
        packed_w[ofs +: DATA_IN_W] = s_data;
        word_end  = (lane_q == LAST_LANE) || s_last;
    end

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        full_d   = full_q;
        done_d   = 1'b0;
        rw_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        buf_d    = buf_q;

        if (start) begin
            state_d  = S_FILL;
            lane_d   = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            full_d   = 1'b0;
            buf_d    = PAD_WORD;
        end else if (accept) begin
            if (word_end) begin
                rw_d     = 1'b1;
                addr_d   = wr_ptr_q;
                data_d   = packed_w;
                count_d  = count_q + 1'b1;
                done_d   = s_last;
                lane_d   = '0;
                buf_d    = PAD_WORD;
                if (wr_ptr_q == LAST_ADDR) begin
                    wr_ptr_d = '0;
                    full_d   = 1'b1;
                    state_d  = S_FULL;
                end else begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (s_last) begin
                        state_d = S_IDLE;
                    end
                end
            end else begin
                buf_d  = packed_w;
                lane_d = lane_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lane_q   <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            done_q   <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            buf_q    <= PAD_WORD;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            done_q   <= done_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            buf_q    <= buf_d;
        end
    end

    assign a_rw       = rw_q;
    assign a_w_addr   = addr_q;
    assign a_indata   = data_q;
    assign word_count = count_q;
    assign full       = full_q;
    assign done       = done_q;

endmodule

// File: tb/tb_asym_ram_write_packer.sv
// Bench for asym_ram_write_packer: queue-based reference model feeds a
// scoreboard; a monitor compares every port-A write against it.
module tb_asym_ram_write_packer;

    localparam int RATIO = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        a_rw;
    logic [7:0]  a_w_addr;
    logic [15:0] a_indata;
    logic [8:0]  word_count;
    logic        full;
    logic        done;

    asym_ram_write_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .a_rw       (a_rw),
        .a_w_addr   (a_w_addr),
        .a_indata   (a_indata),
        .word_count (word_count),
        .full       (full),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        logic        done;
        logic        full;
        logic [8:0]  wc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [7:0]  cur[$];
    int          nwords = 0;
    int          checks = 0;
    int          failures = 0;
    int          nwrites = 0;
    logic [15:0] mem [DEPTH];
    logic [7:0]  b4 [100];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Reference: a word is the accepted bytes, first byte least
    // significant, missing bytes zero; address counts words mod DEPTH.
    task automatic model_accept(input logic [7:0] b, input bit last);
        exp_t e;
        logic [15:0] w;
        cur.push_back(b);
        if (cur.size() == RATIO || last) begin
            w = '0;
            for (int i = 0; i < cur.size(); i++)
                w = w | (16'(cur[i]) << (8 * i));
            e.addr = 8'(nwords % DEPTH);
            e.data = w;
            e.done = last;
            e.wc   = 9'(nwords + 1);
            e.full = (nwords + 1 == DEPTH);
            sbq.push_back(e);
            nwords++;
            cur.delete();
        end
    endtask

    task automatic model_clear();
        cur.delete();
        nwords = 0;
    endtask

    always @(negedge clk) begin
        if (a_rw === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0h data=%0h",
                         a_w_addr, a_indata);
            end else begin
                mon_e = sbq.pop_front();
                if ({a_w_addr, a_indata, done, full, word_count} !==
                    {mon_e.addr, mon_e.data, mon_e.done, mon_e.full, mon_e.wc}) begin
                    failures++;
                    $display("FAIL write got a=%0h d=%0h dn=%0b f=%0b wc=%0d want a=%0h d=%0h dn=%0b f=%0b wc=%0d",
                             a_w_addr, a_indata, done, full, word_count,
                             mon_e.addr, mon_e.data, mon_e.done, mon_e.full, mon_e.wc);
                end
            end
            mem[a_w_addr] = a_indata;
            nwrites++;
        end
    end

    task automatic send(input logic [7:0] b, input bit last, input bit gaps);
        bit acc;
        bit ok;
        ok = 1'b0;
        if (gaps && $urandom_range(1) == 0) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
            @(posedge clk);
        end
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = b;
            s_last  = last;
            acc     = s_ready;
            @(posedge clk);
            if (acc) begin
                model_accept(b, last);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout byte=%0h", b);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input bit with_byte);
        @(negedge clk);
        start   = 1'b1;
        s_valid = with_byte;
        s_data  = 8'h77;
        s_last  = 1'b0;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk(name, {s_ready, a_rw, full, done, a_w_addr, a_indata, word_count}, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        repeat (3) @(negedge clk);
        chk_zero("reset_outs");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", s_ready, 0);

        do_start(1'b0);
        chk("fill_ready", s_ready, 1);
        send(8'h34, 0, 0);
        send(8'h12, 0, 0);
        idle(2);
        chk("t1_word", mem[0], 16'h1234);

        do_start(1'b0);
        send(8'hAA, 0, 0);
        send(8'hBB, 0, 0);
        send(8'hCC, 1, 0);
        idle(2);
        chk("t3_w0", mem[0], 16'hBBAA);
        chk("t3_w1", mem[1], 16'h00CC);
        chk("t3_idle_ready", s_ready, 0);

        do_start(1'b0);
        w0 = nwrites;
        for (int i = 0; i < 512; i++) send(8'(i), 0, 0);
        idle(2);
        chk("t2_writes", nwrites - w0, 256);
        chk("t2_full", full, 1);
        chk("t2_count", word_count, 256);
        chk("t2_ready", s_ready, 0);
        for (int k = 0; k < DEPTH; k++)
            chk("t2_mem", mem[k], {8'(2 * k + 1), 8'(2 * k)});

        do_start(1'b0);
        chk("restart_full", full, 0);
        for (int i = 0; i < 100; i++) b4[i] = 8'($urandom);
        for (int i = 0; i < 100; i++) send(b4[i], i == 99, 1);
        idle(2);
        for (int k = 0; k < 50; k++)
            chk("t4_mem", mem[k], {b4[2 * k + 1], b4[2 * k]});

        do_start(1'b0);
        for (int i = 0; i < 20; i++) send(8'($urandom), 0, 1);
        do_start(1'b1);
        chk("t6_count", word_count, 0);
        send(8'h55, 0, 0);
        send(8'h66, 0, 0);
        idle(2);
        chk("t6_mem0", mem[0], 16'h6655);

        do_start(1'b0);
        for (int i = 0; i < 11; i++) send(8'(8'h40 + i), 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("t5_reset_outs");
        chk("t5_sb_empty", sbq.size(), 0);
        model_clear();
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("t5_held");
        rst_n = 1'b1;
        do_start(1'b0);
        send(8'h01, 0, 0);
        send(8'h02, 0, 0);
        idle(2);
        chk("t5_mem0", mem[0], 16'h0201);

        repeat (3) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
